// File: rtl/mem_access_pkg.sv
// Shared types, ALU op codes and exception codes for the memory stage.
// Also holds the op-decoding helpers used by the stage and its lane-alignment logic.
package mem_access_pkg;

    typedef logic [7:0]  aluop_bus_t;
    typedef logic [31:0] reg_bus_t;

    localparam logic     RstEnable = 1'b1;
    localparam reg_bus_t ZeroWord  = 32'h0000_0000;

    localparam aluop_bus_t ALU_OP_NOP = 8'h00;
    localparam aluop_bus_t ALU_OP_ADD = 8'h20;
    localparam aluop_bus_t ALU_OP_OR  = 8'h25;
    localparam aluop_bus_t ALU_OP_LB  = 8'hE0;
    localparam aluop_bus_t ALU_OP_LH  = 8'hE1;
    localparam aluop_bus_t ALU_OP_LW  = 8'hE3;
    localparam aluop_bus_t ALU_OP_SB  = 8'hE8;
    localparam aluop_bus_t ALU_OP_SH  = 8'hE9;
    localparam aluop_bus_t ALU_OP_SW  = 8'hEB;

    typedef enum logic [1:0] {
        EXC_NONE    = 2'd0,
        EXC_ALIGN   = 2'd1,
        EXC_TIMEOUT = 2'd2
    } exc_t;

    function automatic logic is_mem_op(input aluop_bus_t op);
        case (op)
            ALU_OP_LB, ALU_OP_LH, ALU_OP_LW,
            ALU_OP_SB, ALU_OP_SH, ALU_OP_SW: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input aluop_bus_t op);
        case (op)
            ALU_OP_SB, ALU_OP_SH, ALU_OP_SW: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input aluop_bus_t op, input logic [1:0] lo);
        case (op)
            ALU_OP_LH, ALU_OP_SH: return lo[0];
            ALU_OP_LW, ALU_OP_SW: return (lo != 2'b00);
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/acknowledge data-memory bus between the memory stage (master) and memory (slave).
interface mem_access_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_dm_lane_align.sv
// Little-endian byte-lane steering: lane enables, store replication and load extension.
module mem_access_dm_lane_align
    import mem_access_pkg::*;
(
    input  aluop_bus_t  op,
    input  logic [1:0]  addr_lo,
    input  reg_bus_t    st_src,
    input  reg_bus_t    rdata,
    output logic [3:0]  sel,
    output reg_bus_t    st_data,
    output reg_bus_t    ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = rdata[{addr_lo, 3'b000} +: 8];
    assign half_s = rdata[{addr_lo[1], 4'b0000} +: 16];

    // Decode lanes and data shaping from the access size.
    always_comb begin
        sel     = 4'b0000;
        st_data = ZeroWord;
        ld_data = ZeroWord;
        case (op)
            ALU_OP_LB: begin
                sel     = 4'b0001 << addr_lo;
                ld_data = {{24{byte_s[7]}}, byte_s};
            end
            ALU_OP_LH: begin
                sel     = 4'b0011 << {addr_lo[1], 1'b0};
                ld_data = {{16{half_s[15]}}, half_s};
            end
            ALU_OP_LW: begin
                sel     = 4'b1111;
                ld_data = rdata;
            end
            ALU_OP_SB: begin
                sel     = 4'b0001 << addr_lo;
                st_data = {4{st_src[7:0]}};
            end
            ALU_OP_SH: begin
                sel     = 4'b0011 << {addr_lo[1], 1'b0};
                st_data = {2{st_src[15:0]}};
            end
            ALU_OP_SW: begin
                sel     = 4'b1111;
                st_data = st_src;
            end
            default: begin
                sel     = 4'b0000;
                st_data = ZeroWord;
                ld_data = ZeroWord;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MIPS memory stage: issues loads/stores on the data bus, stalls until acknowledge or
// timeout, and registers the write-back bundle with an exception code.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned DM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  reg_bus_t          wdata_i,
    input  aluop_bus_t        aluop_i,
    input  reg_bus_t          mem_addr_i,
    input  reg_bus_t          reg2_i,
    input  reg_bus_t          pc_i,
    mem_access_if.master      dm,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output reg_bus_t          wdata_o,
    output reg_bus_t          pc_o,
    output logic [1:0]        exc_o,
    output logic              stallreq_o
);

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    localparam logic [7:0] TMO_LAST = 8'(DM_TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    aluop_bus_t  op_r;
    logic [1:0]  addr_lo_r;
    logic        req_r;
    logic        we_r;
    reg_bus_t    addr_r;
    logic [3:0]  sel_r;
    reg_bus_t    wdata_r;
    exc_t        exc_r;

    logic        mem_op_s;
    logic        misalign_s;
    logic        timeout_s;
    logic        stall_s;
    aluop_bus_t  lane_op_s;
    logic [1:0]  lane_lo_s;
    logic [3:0]  sel_s;
    reg_bus_t    st_data_s;
    reg_bus_t    ld_data_s;

    assign mem_op_s   = is_mem_op(aluop_i);
    assign misalign_s = is_misaligned(aluop_i, mem_addr_i[1:0]);
    assign timeout_s  = (cnt_r == TMO_LAST);

    // While waiting, load extension must follow the access that was issued, not EX.
    assign lane_op_s = (state_r == ST_WAIT) ? op_r      : aluop_i;
    assign lane_lo_s = (state_r == ST_WAIT) ? addr_lo_r : mem_addr_i[1:0];

    mem_access_dm_lane_align u_lane (
        .op      (lane_op_s),
        .addr_lo (lane_lo_s),
        .st_src  (reg2_i),
        .rdata   (dm.rdata),
        .sel     (sel_s),
        .st_data (st_data_s),
        .ld_data (ld_data_s)
    );

    // Freeze request: asserted while an access is about to start or is still outstanding.
    always_comb begin
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s && !misalign_s) stall_s = 1'b1;
                else                         stall_s = 1'b0;
            end
            ST_WAIT: begin
                if (dm.ack || timeout_s) stall_s = 1'b0;
                else                     stall_s = 1'b1;
            end
            default: stall_s = 1'b0;
        endcase
    end

    assign stallreq_o = stall_s;
    assign exc_o      = exc_r;
    assign dm.req     = req_r;
    assign dm.we      = we_r;
    assign dm.addr    = addr_r;
    assign dm.sel     = sel_r;
    assign dm.wdata   = wdata_r;

    // Access FSM with registered bus and write-back outputs.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            op_r      <= ALU_OP_NOP;
            addr_lo_r <= 2'b00;
            req_r     <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= ZeroWord;
            sel_r     <= 4'b0000;
            wdata_r   <= ZeroWord;
            wd_o      <= 5'd0;
            wreg_o    <= 1'b0;
            wdata_o   <= ZeroWord;
            pc_o      <= ZeroWord;
            exc_r     <= EXC_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!mem_op_s) begin
                        wd_o    <= wd_i;
                        wreg_o  <= wreg_i;
                        wdata_o <= wdata_i;
                        pc_o    <= pc_i;
                        exc_r   <= EXC_NONE;
                    end else if (misalign_s) begin
                        wd_o    <= 5'd0;
                        wreg_o  <= 1'b0;
                        wdata_o <= ZeroWord;
                        pc_o    <= pc_i;
                        exc_r   <= EXC_ALIGN;
                    end else begin
                        req_r     <= 1'b1;
                        we_r      <= is_store(aluop_i);
                        addr_r    <= {mem_addr_i[31:2], 2'b00};
                        sel_r     <= sel_s;
                        wdata_r   <= st_data_s;
                        op_r      <= aluop_i;
                        addr_lo_r <= mem_addr_i[1:0];
                        cnt_r     <= 8'd0;
                        wd_o      <= 5'd0;
                        wreg_o    <= 1'b0;
                        wdata_o   <= ZeroWord;
                        pc_o      <= pc_i;
                        exc_r     <= EXC_NONE;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dm.ack) begin
                        req_r   <= 1'b0;
                        we_r    <= 1'b0;
                        wd_o    <= wd_i;
                        wreg_o  <= is_store(op_r) ? 1'b0 : wreg_i;
                        wdata_o <= is_store(op_r) ? wdata_i : ld_data_s;
                        pc_o    <= pc_i;
                        exc_r   <= EXC_NONE;
                        state_r <= ST_IDLE;
                    end else if (timeout_s) begin
                        req_r   <= 1'b0;
                        we_r    <= 1'b0;
                        wd_o    <= 5'd0;
                        wreg_o  <= 1'b0;
                        wdata_o <= ZeroWord;
                        pc_o    <= pc_i;
                        exc_r   <= EXC_TIMEOUT;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed table, randomized traffic against a
// transaction-level model, and a reset-during-access sequence.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TMO = 4;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, reg2, rdata, wdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] pc;
        int          d;
    } stim_t;

    typedef struct {
        int          stall, req;
        logic        we;
        logic [31:0] baddr;
        logic [3:0]  sel;
        logic [31:0] bwdata;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] wbdata, pc;
        logic [1:0]  exc;
        logic        chk_data, chk_pc;
    } exp_t;

    typedef struct { stim_t s; exp_t e; } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, mem_addr_i, reg2_i, pc_i;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o, pc_o;
    logic [1:0]  exc_o;
    logic        stallreq_o;
    int errors = 0;
    int checks = 0;

    mem_access_if bus();

    mem_access #(.DM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .pc_i(pc_i),
        .dm(bus), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .pc_o(pc_o),
        .exc_o(exc_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: outcome of one instruction through the stage.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        int b, sz, n;
        logic ld, st;
        logic [31:0] v;
        e = '{0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0};
        b  = int'(s.addr[1:0]);
        ld = (s.op == ALU_OP_LB) || (s.op == ALU_OP_LH) || (s.op == ALU_OP_LW);
        st = (s.op == ALU_OP_SB) || (s.op == ALU_OP_SH) || (s.op == ALU_OP_SW);
        sz = (s.op == ALU_OP_LB || s.op == ALU_OP_SB) ? 1 :
             (s.op == ALU_OP_LH || s.op == ALU_OP_SH) ? 2 : 4;
        if (!ld && !st) begin
            e.wreg = s.wreg; e.wd = s.wd; e.wbdata = s.wdata; e.pc = s.pc;
            e.chk_data = 1'b1; e.chk_pc = 1'b1;
        end else if (b % sz != 0) begin
            e.exc = 2'd1; e.pc = s.pc; e.chk_pc = 1'b1;
        end else begin
            n = (s.d < TMO) ? s.d + 1 : TMO;
            e.stall = n; e.req = n; e.we = st;
            e.baddr = s.addr & 32'hFFFF_FFFC;
            e.sel = (sz == 1) ? 4'(1 << b) : (sz == 2) ? 4'(3 << ((b / 2) * 2)) : 4'hF;
            e.bwdata = (sz == 1) ? (s.reg2 & 32'hFF) * 32'h0101_0101 :
                       (sz == 2) ? (s.reg2 & 32'hFFFF) * 32'h0001_0001 : s.reg2;
            if (s.d >= TMO) begin
                e.exc = 2'd2;
            end else begin
                e.wreg = ld ? s.wreg : 1'b0;
                e.wd = s.wd;
                if (ld) begin
                    e.chk_data = 1'b1;
                    if (sz == 1) begin
                        v = (s.rdata >> (8 * b)) & 32'hFF;
                        if (v >= 32'd128) v = v + 32'hFFFF_FF00;
                    end else if (sz == 2) begin
                        v = (s.rdata >> (16 * (b / 2))) & 32'hFFFF;
                        if (v >= 32'd32768) v = v + 32'hFFFF_0000;
                    end else begin
                        v = s.rdata;
                    end
                    e.wbdata = v;
                end
            end
        end
        return e;
    endfunction

    // Drive one instruction, act as memory acking after s.d WAIT cycles, then check.
    task automatic run(input stim_t s, input exp_t e, input string tag);
        int stall_n, req_n;
        bit seen, done;
        stall_n = 0; req_n = 0; seen = 1'b0; done = 1'b0;
        @(negedge clk);
        aluop_i = s.op; mem_addr_i = s.addr; reg2_i = s.reg2; wdata_i = s.wdata;
        wd_i = s.wd; wreg_i = s.wreg; pc_i = s.pc;
        for (int cyc = 0; cyc < 16 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus.req) begin
                bus.ack   = (req_n == s.d);
                bus.rdata = s.rdata;
            end else begin
                bus.ack   = 1'($urandom_range(0, 1));
                bus.rdata = $urandom;
            end
            #1;
            if (bus.req) begin
                if (!seen) begin
                    chk({tag, " addr"}, bus.addr, e.baddr);
                    chk({tag, " sel"}, 32'(bus.sel), 32'(e.sel));
                    chk({tag, " we"}, 32'(bus.we), 32'(e.we));
                    if (e.we) chk({tag, " bus_wdata"}, bus.wdata, e.bwdata);
                end
                seen = 1'b1;
                req_n++;
            end
            if (stallreq_o) stall_n++;
            else            done = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.ack = 1'b0;
        if (!done) chk({tag, " completion bound"}, 32'd0, 32'd1);
        chk({tag, " stall_cycles"}, 32'(stall_n), 32'(e.stall));
        chk({tag, " req_cycles"}, 32'(req_n), 32'(e.req));
        chk({tag, " exc"}, 32'(exc_o), 32'(e.exc));
        chk({tag, " wreg"}, 32'(wreg_o), 32'(e.wreg));
        if (e.wreg) chk({tag, " wd"}, 32'(wd_o), 32'(e.wd));
        if (e.chk_data) chk({tag, " wdata"}, wdata_o, e.wbdata);
        if (e.chk_pc) chk({tag, " pc"}, pc_o, e.pc);
    endtask

    vec_t tbl[10];
    stim_t rs;
    logic [7:0] ops[8];

    initial begin
        tbl[0] = '{'{ALU_OP_OR, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 5'd3, 1'b1, 32'h0000_1000, 0},
                   '{0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 5'd3, 32'h0000_1234, 32'h0000_1000, 2'd0, 1'b1, 1'b1}};
        tbl[1] = '{'{ALU_OP_SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd2, 1'b1, 32'h0000_1004, 0},
                   '{1, 1, 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0}};
        tbl[2] = '{'{ALU_OP_LB, 32'h203, 32'h0, 32'h8011_2233, 32'h0, 5'd7, 1'b1, 32'h0000_1008, 2},
                   '{3, 3, 1'b0, 32'h200, 4'h8, 32'h0, 1'b1, 5'd7, 32'hFFFF_FF80, 32'h0, 2'd0, 1'b1, 1'b0}};
        tbl[3] = '{'{ALU_OP_SH, 32'h302, 32'h0000_ABCD, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0000_100C, 1},
                   '{2, 2, 1'b1, 32'h300, 4'hC, 32'hABCD_ABCD, 1'b0, 5'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0}};
        tbl[4] = '{'{ALU_OP_LH, 32'h301, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 32'h0000_1010, 0},
                   '{0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0000_1010, 2'd1, 1'b0, 1'b1}};
        tbl[5] = '{'{ALU_OP_LW, 32'h400, 32'h0, 32'h1234_5678, 32'h0, 5'd5, 1'b1, 32'h0000_1014, 99},
                   '{4, 4, 1'b0, 32'h400, 4'hF, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0}};
        tbl[6] = '{'{ALU_OP_LW, 32'h404, 32'h0, 32'h1234_5678, 32'h0, 5'd6, 1'b1, 32'h0000_1018, 3},
                   '{4, 4, 1'b0, 32'h404, 4'hF, 32'h0, 1'b1, 5'd6, 32'h1234_5678, 32'h0, 2'd0, 1'b1, 1'b0}};
        tbl[7] = '{'{ALU_OP_SW, 32'h102, 32'h1111_2222, 32'h0, 32'h0, 5'd1, 1'b1, 32'h0000_101C, 0},
                   '{0, 0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0000_101C, 2'd1, 1'b0, 1'b1}};
        tbl[8] = '{'{ALU_OP_LH, 32'h206, 32'h0, 32'h7FFF_8001, 32'h0, 5'd8, 1'b1, 32'h0000_1020, 0},
                   '{1, 1, 1'b0, 32'h204, 4'hC, 32'h0, 1'b1, 5'd8, 32'h0000_7FFF, 32'h0, 2'd0, 1'b1, 1'b0}};
        tbl[9] = '{'{ALU_OP_LB, 32'h201, 32'h0, 32'h0000_5A00, 32'h0, 5'd9, 1'b1, 32'h0000_1024, 1},
                   '{2, 2, 1'b0, 32'h200, 4'h2, 32'h0, 1'b1, 5'd9, 32'h0000_005A, 32'h0, 2'd0, 1'b1, 1'b0}};
        ops = '{ALU_OP_OR, ALU_OP_ADD, ALU_OP_LB, ALU_OP_LH, ALU_OP_LW, ALU_OP_SB, ALU_OP_SH, ALU_OP_SW};

        rst = 1'b1; aluop_i = ALU_OP_NOP; mem_addr_i = 32'h0; reg2_i = 32'h0; wdata_i = 32'h0;
        wd_i = 5'd0; wreg_i = 1'b0; pc_i = 32'h0; bus.ack = 1'b0; bus.rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset wreg", 32'(wreg_o), 32'd0);
        chk("reset wd", 32'(wd_o), 32'd0);
        chk("reset wdata", wdata_o, 32'd0);
        chk("reset pc", pc_o, 32'd0);
        chk("reset exc", 32'(exc_o), 32'd0);
        chk("reset req", 32'(bus.req), 32'd0);
        chk("reset bus", {bus.addr[27:0], bus.sel}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run(tbl[i].s, tbl[i].e, $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
            rs.op = ops[$urandom_range(0, 7)];
            rs.addr = $urandom; rs.reg2 = $urandom; rs.rdata = $urandom; rs.wdata = $urandom;
            rs.wd = 5'($urandom); rs.wreg = 1'($urandom); rs.pc = $urandom;
            rs.d = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 0) rs.addr[1:0] = 2'b00;
            run(rs, model(rs), $sformatf("rnd%0d", i));
        end

        // Reset while an access is outstanding: bus drops, in-flight result is lost.
        @(negedge clk);
        aluop_i = ALU_OP_LW; mem_addr_i = 32'h500; wd_i = 5'd11; wreg_i = 1'b1; pc_i = 32'h2000;
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre-reset req", 32'(bus.req), 32'd1);
        chk("pre-reset stall", 32'(stallreq_o), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst-wait req", 32'(bus.req), 32'd0);
        chk("rst-wait wreg", 32'(wreg_o), 32'd0);
        chk("rst-wait exc", 32'(exc_o), 32'd0);
        chk("rst-wait pc", pc_o, 32'd0);
        chk("rst-wait addr", bus.addr, 32'd0);
        @(negedge clk);
        rst = 1'b0; aluop_i = ALU_OP_NOP; wreg_i = 1'b0; bus.ack = 1'b1; bus.rdata = 32'hCAFE_F00D;
        #1;
        chk("late ack stall", 32'(stallreq_o), 32'd0);
        @(posedge clk);
        #1;
        chk("late ack req", 32'(bus.req), 32'd0);
        chk("late ack wreg", 32'(wreg_o), 32'd0);
        chk("late ack exc", 32'(exc_o), 32'd0);
        @(negedge clk);
        bus.ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
